flag_sync_multi: RTL

- Parametrised multi-channel receive-side flag synchroniser, the successor to the single-channel toggle-flag crossing.
- Takes N asynchronous toggle-encoded (or level) flags into the clkB domain through a configurable-depth synchroniser and produces a one-cycle pulse per event.
- Adds features the single-channel version lacks:
  - sticky pending flags with per-channel clear;
  - overflow detection for events arriving while a flag is still pending;
  - saturating per-channel event counters;
  - masking of spurious events after reset.
- Sits at the boundary of AXIS/PWM control logic, feeding status registers and control FSMs.

---
 rtl/flag_sync_multi.sv | 60 ++++++
 1 files changed

// File: rtl/flag_sync_multi.sv
// flag_sync_multi: N-channel async flag synchroniser into clkB with event pulses,
// sticky pending/overflow flags, saturating event counters and a post-reset event mask.
module flag_sync_multi #(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  parameter int PULSE_MODE  = 0
) (
  input  logic                  clkB,
  input  logic                  rst,
  input  logic [N_CH-1:0]       flag_in,
  input  logic [N_CH-1:0]       clr,
  input  logic                  cnt_clr,
  output logic [N_CH-1:0]       pulse_out,
  output logic [N_CH-1:0]       pending,
  output logic [N_CH-1:0]       overflow,
  output logic [N_CH*CNT_W-1:0] cnt_flat
);
  localparam int MW = $clog2(SYNC_STAGES + 2);
  (* ASYNC_REG = "TRUE" *) logic [N_CH-1:0] sync_q [SYNC_STAGES];
  logic [N_CH-1:0]  prev_q, pulse_q, pend_q, ovf_q, pend_d, ovf_d, raw, ev;
  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [CNT_W-1:0] cnt_d [N_CH];
  logic [MW-1:0]    mask_q;
  // prev keeps tracking while masked so levels present at reset release never fire
  always_comb begin
    raw    = (PULSE_MODE != 0) ? sync_q[SYNC_STAGES-1] & ~prev_q : sync_q[SYNC_STAGES-1] ^ prev_q;
    ev     = (mask_q == '0) ? raw : '0;
    pend_d = ev | (pend_q & ~clr);
    ovf_d  = (ev & pend_q & ~clr) | (ovf_q & ~clr);
    for (int i = 0; i < N_CH; i++)
      cnt_d[i] = cnt_clr ? CNT_W'(ev[i]) : (&cnt_q[i] ? cnt_q[i] : cnt_q[i] + CNT_W'(ev[i]));
  end
  always_ff @(posedge clkB or negedge rst) begin
    if (!rst) begin
      for (int j = 0; j < SYNC_STAGES; j++) sync_q[j] <= '0;
      prev_q  <= '0;
      pulse_q <= '0;
      pend_q  <= '0;
      ovf_q   <= '0;
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
      mask_q  <= MW'(SYNC_STAGES + 1);
    end else begin
      sync_q[0] <= flag_in;
      for (int j = 1; j < SYNC_STAGES; j++) sync_q[j] <= sync_q[j-1];
      prev_q  <= sync_q[SYNC_STAGES-1];
      pulse_q <= ev;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      if (mask_q != '0) mask_q <= mask_q - MW'(1);
    end
  end
  assign pulse_out = pulse_q;
  assign pending   = pend_q;
  assign overflow  = ovf_q;
  for (genvar g = 0; g < N_CH; g++) begin : g_cnt
    assign cnt_flat[g*CNT_W +: CNT_W] = cnt_q[g];
  end
endmodule
